// File: rtl/fp_compare_resolver_pkg.sv
// Shared definitions for the IEEE-754 comparator resolver stage.
//   - Result codes (same encoding as the sign_comparator verdict)
//   - FSM state encoding
//   - binary32 default field widths
//   - sign_verdict(): the verdict sign_comparator must produce for two sign bits
package fp_compare_resolver_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;

    localparam logic [2:0] CMP_EQ    = 3'b100;
    localparam logic [2:0] CMP_XGT   = 3'b010;
    localparam logic [2:0] CMP_YGT   = 3'b001;
    localparam logic [2:0] CMP_UNORD = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLASS = 2'd1,
        ST_MAG   = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Positive beats negative; equal signs defer to magnitude (reported as EQ).
    function automatic logic [2:0] sign_verdict(input logic sx, input logic sy);
        if (!sx && sy)      return CMP_XGT;
        else if (sx && !sy) return CMP_YGT;
        else                return CMP_EQ;
    endfunction

endpackage

// File: rtl/fp_magnitude_compare.sv
// Combinational unsigned compare of the {exponent, mantissa} fields.
// Because IEEE-754 magnitudes are monotonic in this bit pattern, infinities
// and subnormals order correctly without special handling.
//   a, b : W-1-bit magnitude fields (sign stripped)
//   gt   : a > b
//   eq   : a == b
module fp_magnitude_compare #(
    parameter int MW = 31
) (
    input  logic [MW-1:0] a,
    input  logic [MW-1:0] b,
    output logic          gt,
    output logic          eq
);

    assign gt = (a > b);
    assign eq = (a == b);

endmodule

// File: rtl/fp_compare_resolver.sv
// Resolver stage downstream of sign_comparator. Registers one operand pair
// with its sign verdict, resolves protocol errors, NaN and signed zero,
// falls back to a magnitude compare for equal signs, and returns the result.
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid/in_ready : operand bundle handshake (x, y, sign_cmp)
//   out_valid/out_ready : result handshake (result)
//   protocol_err      : sticky, sign_cmp disagreed with operand signs
//   cmp_count         : saturating count of completed result handshakes
//   dbg_state         : current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE. out_valid, once high, stays high
// with result unchanged until the transfer; out_ready is ignored otherwise.
module fp_compare_resolver
    import fp_compare_resolver_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF,
    parameter int CNT_W = 16,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
    input  logic [2:0]       sign_cmp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       result,
    output logic             protocol_err,
    output logic [CNT_W-1:0] cmp_count,
    output logic [1:0]       dbg_state
);

    state_t         state;
    logic [W-1:0]   x_q;
    logic [W-1:0]   y_q;
    logic [2:0]     sc_q;

    logic           nan_x, nan_y, both_zero;
    logic           mag_gt, mag_eq;

    assign nan_x     = (&x_q[W-2:MAN_W]) && (|x_q[MAN_W-1:0]);
    assign nan_y     = (&y_q[W-2:MAN_W]) && (|y_q[MAN_W-1:0]);
    assign both_zero = ~|x_q[W-2:0] && ~|y_q[W-2:0];

    fp_magnitude_compare #(.MW(W-1)) u_mag (
        .a  (x_q[W-2:0]),
        .b  (y_q[W-2:0]),
        .gt (mag_gt),
        .eq (mag_eq)
    );

    assign in_ready  = (state == ST_IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            sc_q         <= '0;
            out_valid    <= 1'b0;
            result       <= CMP_UNORD;
            protocol_err <= 1'b0;
            cmp_count    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_q   <= x;
                        y_q   <= y;
                        sc_q  <= sign_cmp;
                        state <= ST_CLASS;
                    end
                end
                ST_CLASS: begin
                    if (sc_q != sign_verdict(x_q[W-1], y_q[W-1])) begin
                        result       <= CMP_UNORD;
                        protocol_err <= 1'b1;
                        state        <= ST_RESP;
                    end else if (nan_x || nan_y) begin
                        result <= CMP_UNORD;
                        state  <= ST_RESP;
                    end else if (both_zero) begin
                        result <= CMP_EQ;
                        state  <= ST_RESP;
                    end else if (sc_q == CMP_XGT || sc_q == CMP_YGT) begin
                        result <= sc_q;
                        state  <= ST_RESP;
                    end else begin
                        state <= ST_MAG;
                    end
                end
                ST_MAG: begin
                    // Signs are equal here; a negative pair inverts the order.
                    if (mag_eq)                result <= CMP_EQ;
                    else if (mag_gt ^ x_q[W-1]) result <= CMP_XGT;
                    else                        result <= CMP_YGT;
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    // First RESP cycle raises out_valid; result is already settled.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                        if (cmp_count != {CNT_W{1'b1}})
                            cmp_count <= cmp_count + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_compare_resolver.sv
module tb_fp_compare_resolver;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      x;
    logic [31:0]      y;
    logic [2:0]       sign_cmp;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       result;
    logic             protocol_err;
    logic [CNT_W-1:0] cmp_count;
    logic [1:0]       dbg_state;

    int total = 0;
    int bad   = 0;

    logic [2:0] exp_q[$];
    int         lat_q[$];
    int         exp_cnt = 0;
    logic       exp_err = 1'b0;

    fp_compare_resolver #(.EXP_W(8), .MAN_W(23), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .x            (x),
        .y            (y),
        .sign_cmp     (sign_cmp),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .protocol_err (protocol_err),
        .cmp_count    (cmp_count),
        .dbg_state    (dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: order by signed integer key (sign-magnitude to two's complement).
    function automatic logic [2:0] ref_cmp(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] sc, output logic err,
                                           output int lat);
        logic [2:0] ev;
        longint ka, kb;
        bit nan_a, nan_b;
        ev = (a[31] == b[31]) ? 3'b100 : (a[31] ? 3'b001 : 3'b010);
        err = (sc != ev);
        lat = 2;
        if (err) return 3'b000;
        nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        if (nan_a || nan_b) return 3'b000;
        ka = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
        kb = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
        if (a[31] == b[31] && (a[30:0] != 0 || b[30:0] != 0)) lat = 3;
        if (ka == kb) return 3'b100;
        return (ka > kb) ? 3'b010 : 3'b001;
    endfunction

    function automatic logic [2:0] good_sc(input logic [31:0] a, input logic [31:0] b);
        return (a[31] == b[31]) ? 3'b100 : (a[31] ? 3'b001 : 3'b010);
    endfunction

    // driver + scoreboard for one compare; hold = cycles of out_ready=0 after out_valid
    task automatic run_txn(input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] sc, input int hold);
        logic [2:0] er;
        logic e_err;
        int el, n, w;
        logic [2:0] got;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 8) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        x = a; y = b; sign_cmp = sc; in_valid = 1'b1;
        out_ready = (hold == 0);
        er = ref_cmp(a, b, sc, e_err, el);
        exp_q.push_back(er);
        lat_q.push_back(el);
        if (e_err) exp_err = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid && n < 10);
        if (!out_valid) begin
            check("out_valid_timeout", 32'(out_valid), 32'd1);
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
            return;
        end
        got = result;
        check("result", 32'(result), 32'(exp_q.pop_front()));
        check("latency", 32'(n), 32'(lat_q.pop_front()));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_result", 32'(result), 32'(got));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        if (exp_cnt < 15) exp_cnt++;
        check("valid_drop", 32'(out_valid), 32'd0);
        check("cmp_count", 32'(cmp_count), 32'(exp_cnt));
        check("protocol_err", 32'(protocol_err), 32'(exp_err));
    endtask

    function automatic logic [31:0] pick_op();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h00000000;
            1: v = 32'h7F800000;
            2: v = 32'h7FC00001;
            3: v = 32'h00000001;
            4: v = 32'h3F800000;
            default: v = $urandom;
        endcase
        if ($urandom_range(0, 1) == 1) v[31] = ~v[31];
        return v;
    endfunction

    initial begin
        logic [31:0] a, b;
        logic [2:0]  sc;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        x = '0; y = '0; sign_cmp = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_err", 32'(protocol_err), 32'd0);
        check("rst_count", 32'(cmp_count), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // directed
        run_txn(32'h3F800000, 32'hBF800000, 3'b010, 0);
        run_txn(32'h40000000, 32'h3F800000, 3'b100, 0);
        run_txn(32'hC0000000, 32'hBF800000, 3'b100, 0);
        run_txn(32'h40490FDB, 32'h40490FDB, 3'b100, 0);
        run_txn(32'h00000000, 32'h80000000, 3'b010, 0);
        run_txn(32'h7FC00000, 32'h3F800000, 3'b100, 0);
        run_txn(32'h7F800000, 32'h7F7FFFFF, 3'b100, 0);
        run_txn(32'h00000001, 32'h00000002, 3'b100, 0);
        // backpressure
        run_txn(32'hBF800000, 32'hC0000000, 3'b100, 5);
        // protocol error, then confirm it stays set
        run_txn(32'h3F800000, 32'hBF800000, 3'b100, 0);
        run_txn(32'h3F800000, 32'h3F800000, 3'b011, 0);
        run_txn(32'h3F800000, 32'h40000000, 3'b100, 2);

        // reset while in MAG
        @(negedge clk);
        x = 32'h40000000; y = 32'h3F800000; sign_cmp = 3'b100; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_state_mag", 32'(dbg_state), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_err", 32'(protocol_err), 32'd0);
        check("midrst_count", 32'(cmp_count), 32'd0);
        exp_cnt = 0; exp_err = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // random traffic, 17+ handshakes to exercise saturation
        for (int i = 0; i < 20; i++) begin
            a = pick_op();
            b = pick_op();
            sc = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : good_sc(a, b);
            run_txn(a, b, sc, $urandom_range(0, 2));
        end
        check("count_saturated", 32'(cmp_count), 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
